jtgng_sdram_arb: RTL and testbench
==================================

// Module: jtgng_sdram_arb
// PURPOSE
//  Shares the single SDRAM read port among SLOTS ROM requesters (CPU, sound, char, scroll, obj).
//  Each slot keeps a one-word (32-bit) cache tagged by address; hits return without SDRAM access.
//  Misses are arbitrated round-robin and issued as read_req/sdram_addr to the SDRAM controller.
//  Drives refresh_en so auto-refresh only runs while no slot is waiting.
// PARAMETERS
//  SLOTS  4   number of requesters (2..8)
//  AW     22  SDRAM word address width
//  DW     32  data width per read (two 16-bit SDRAM beats)
// PORTS
//  clk          in   1          system clock, same as SDRAM controller
//  rst          in   1          synchronous, active-high reset
//  loop_rst     in   1          SDRAM controller initialising; no requests issued while high
//  downloading  in   1          ROM download in progress; invalidates all caches
//  slot_req     in   SLOTS      per-slot request level
//  slot_addr    in   SLOTS*AW   per-slot word address, slot i at [i*AW +: AW]
//  slot_dout    out  SLOTS*DW   per-slot cached data, slot i at [i*DW +: DW]
//  slot_ok      out  SLOTS      slot_dout valid for current slot_addr
//  read_req     out  1          read strobe to SDRAM controller
//  sdram_addr   out  AW         read address to SDRAM controller
//  sdram_ack    in   1          controller accepted read_req (1-cycle pulse)
//  data_rdy     in   1          data_read valid (1-cycle pulse)
//  data_read    in   DW         read data from controller
//  refresh_en   out  1          high when no slot miss is pending and FSM idle
// BEHAVIOUR
//  Reset: read_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, refresh_en=0, all valid=0,
//   rr pointer=SLOTS-1, FSM=IDLE. Reset mid-transaction discards it; pending data_rdy ignored.
//  Per slot: hit_i = valid_i & (tag_i == addr_i); miss_i = req_i & ~hit_i.
//  slot_ok_i registered: slot_ok_i <= req_i & hit_i & ~downloading. Hit latency 1 cycle.
//   slot_ok may be high for one cycle after an address change; requesters hold addr one
//   cycle before sampling ok.
//  FSM:
//   IDLE: if any miss & ~downloading & ~loop_rst: grant g = first miss after rr pointer
//    (wrapping); sdram_addr<=addr_g, tag_g<=addr_g, valid_g<=0, read_req<=1,
//    rr<=g -> WAIT_ACK. Else stay; refresh_en<=~|miss.
//   WAIT_ACK: on sdram_ack: read_req<=0 -> WAIT_DATA. read_req held until ack.
//   WAIT_DATA: on data_rdy: slot_dout_g<=data_read; valid_g<=~dl_seen -> IDLE.
//  refresh_en=0 in WAIT_ACK/WAIT_DATA and in IDLE while any miss pending.
//  Miss latency: grant cycle + controller ack + ~5 cycles; slot_ok 1 cycle after data_rdy.
//  downloading: every cycle high clears all valid; sets dl_seen (cleared in IDLE) so an
//   in-flight read completes normally but its data is not validated. No new grants.
//  Slot address changes while its read is in flight: data stored against captured tag;
//   new address simply misses again next IDLE (no cancel).
//  Simultaneous sdram_ack and data_rdy in WAIT_ACK: ack processed; data_rdy cannot
//   occur before ack by controller contract.
//  Non-requesting slots keep valid/tag/dout (cache persists across req drops).
//  Fairness: a continuously missing slot is granted within SLOTS grants.
// STRUCTURE
//  Shared include jtgng_sdram_defs.vh: FSM state encodings (IDLE/WAIT_ACK/WAIT_DATA).
//  Sub-module jtgng_rr_pick: combinational round-robin picker, inputs miss vector
//   and pointer, outputs one-hot grant + index + any flag. Tag compare/valid in generate loop.
// TESTING (bench models controller: ack 1 cycle after read_req, data_rdy 5 cycles later)
//  1 slot0 req addr 0x00100, cold -> one read_req with sdram_addr=0x00100; slot_ok0 1 cycle
//   after data_rdy, slot_dout0=model word; re-request same addr -> ok 1 cycle, no read_req.
//  2 slots 0..3 miss together -> grants in order 0,1,2,3; rerun with rr=1 -> 2,3,0,1.
//  3 slot2 changes addr 0x2000->0x2001 during WAIT_DATA -> ok stays low, second read of 0x2001.
//  4 downloading pulsed during WAIT_DATA -> read completes, slot_ok stays 0, all valid cleared,
//   next req re-fetches.
//  5 no requests for 20 cycles -> refresh_en=1; slot1 miss -> refresh_en=0 same cycle as grant.
//  6 rst asserted in WAIT_ACK -> next cycle read_req=0, slot_ok=0, FSM IDLE, caches empty.

Source files
------------

// File: rtl/jtgng_sdram_arb_pkg.sv
// Shared definitions for the SDRAM read-port arbiter: FSM encodings and
// small index helpers used by the arbiter and its round-robin picker.
package jtgng_sdram_arb_pkg;

    localparam int ST_W = 2;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd1;
    localparam logic [1:0] ST_WAIT_DATA = 2'd2;

    function automatic int ptr_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

    // Slot index 'step' positions after 'base', wrapping modulo n (step <= n).
    function automatic int wrap_idx(input int base, input int step, input int n);
        int s;
        s = base + step;
        if (s >= n) begin
            return s - n;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/jtgng_sdram_arb_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of the miss
// vector strictly after the pointer, wrapping, as one-hot plus index.
module jtgng_rr_pick
    import jtgng_sdram_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int PW    = 2
)(
    input  logic [SLOTS-1:0] miss,
    input  logic [PW-1:0]    ptr,
    output logic [SLOTS-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             any
);

    // Scan from ptr+1 around to ptr itself; the first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 1; k <= SLOTS; k++) begin
            if (!any && miss[wrap_idx(int'(ptr), k, SLOTS)]) begin
                any = 1'b1;
                idx = PW'(wrap_idx(int'(ptr), k, SLOTS));
                grant[wrap_idx(int'(ptr), k, SLOTS)] = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/jtgng_sdram_arb.sv
// SDRAM read-port arbiter: one-word tagged cache per ROM slot, round-robin
// miss service towards the SDRAM controller, refresh gating while idle.
module jtgng_sdram_arb
    import jtgng_sdram_arb_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = 22,
    parameter int DW    = 32
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                loop_rst,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_req,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic [SLOTS-1:0]    slot_ok,
    output logic                read_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en
);

    localparam int PW = ptr_width(SLOTS);

    logic [ST_W-1:0]     state_q,    state_d;
    logic [PW-1:0]       rr_q,       rr_d;
    logic [PW-1:0]       gnt_q,      gnt_d;
    logic [SLOTS-1:0]    valid_q,    valid_d;
    logic [SLOTS*AW-1:0] tag_q,      tag_d;
    logic [SLOTS*DW-1:0] dout_q,     dout_d;
    logic [SLOTS-1:0]    ok_q,       ok_d;
    logic                read_req_q, read_req_d;
    logic [AW-1:0]       addr_q,     addr_d;
    logic                refresh_q,  refresh_d;
    logic                dl_seen_q,  dl_seen_d;

    logic [SLOTS-1:0]    hit_s;
    logic [SLOTS-1:0]    miss_s;
    logic [SLOTS-1:0]    fill_s;
    logic [SLOTS-1:0]    pick_grant_s;
    logic [PW-1:0]       pick_idx_s;
    logic                pick_any_s;

    // fill_s lets slot_ok rise on the edge that captures data_rdy, as long as
    // the requester still points at the address that was fetched.
    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        assign hit_s[i]  = valid_q[i] & (tag_q[i*AW +: AW] == slot_addr[i*AW +: AW]);
        assign miss_s[i] = slot_req[i] & ~hit_s[i];
        assign fill_s[i] = (state_q == ST_WAIT_DATA) & data_rdy & (gnt_q == PW'(i))
                         & ~dl_seen_q & (tag_q[i*AW +: AW] == slot_addr[i*AW +: AW]);
    end

    jtgng_rr_pick #(
        .SLOTS (SLOTS),
        .PW    (PW)
    ) u_pick (
        .miss  (miss_s),
        .ptr   (rr_q),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // Next-state logic for the request FSM, cache tags/valids and outputs.
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        dout_d     = dout_q;
        read_req_d = read_req_q;
        addr_d     = addr_q;
        refresh_d  = 1'b0;
        ok_d       = slot_req & (hit_s | fill_s) & {SLOTS{~downloading}};

        if (downloading) begin
            dl_seen_d = 1'b1;
        end else if (state_q == ST_IDLE) begin
            dl_seen_d = 1'b0;
        end else begin
            dl_seen_d = dl_seen_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any_s && !downloading && !loop_rst) begin
                    state_d    = ST_WAIT_ACK;
                    rr_d       = pick_idx_s;
                    gnt_d      = pick_idx_s;
                    addr_d     = slot_addr[int'(pick_idx_s)*AW +: AW];
                    tag_d[int'(pick_idx_s)*AW +: AW] = slot_addr[int'(pick_idx_s)*AW +: AW];
                    valid_d    = valid_q & ~pick_grant_s;
                    read_req_d = 1'b1;
                end else begin
                    refresh_d  = ~|miss_s;
                end
            end
            ST_WAIT_ACK: begin
                if (sdram_ack) begin
                    read_req_d = 1'b0;
                    state_d    = ST_WAIT_DATA;
                end else begin
                    read_req_d = 1'b1;
                end
            end
            ST_WAIT_DATA: begin
                if (data_rdy) begin
                    dout_d[int'(gnt_q)*DW +: DW] = data_read;
                    valid_d[gnt_q] = ~dl_seen_q;
                    state_d        = ST_IDLE;
                end else begin
                    state_d        = ST_WAIT_DATA;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                read_req_d = 1'b0;
            end
        endcase

        // A download wipes every cached word, including one being filled now.
        if (downloading) begin
            valid_d = '0;
        end else begin
            valid_d = valid_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_q       <= PW'(SLOTS-1);
            gnt_q      <= '0;
            valid_q    <= '0;
            tag_q      <= '0;
            dout_q     <= '0;
            ok_q       <= '0;
            read_req_q <= 1'b0;
            addr_q     <= '0;
            refresh_q  <= 1'b0;
            dl_seen_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            dout_q     <= dout_d;
            ok_q       <= ok_d;
            read_req_q <= read_req_d;
            addr_q     <= addr_d;
            refresh_q  <= refresh_d;
            dl_seen_q  <= dl_seen_d;
        end
    end

    assign slot_dout  = dout_q;
    assign slot_ok    = ok_q;
    assign read_req   = read_req_q;
    assign sdram_addr = addr_q;
    assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jtgng_sdram_arb.sv
// Directed/randomised bench for jtgng_sdram_arb with a behavioural SDRAM
// controller (ack 1 cycle after read_req, data 5 cycles after ack).
module tb_jtgng_sdram_arb;

    localparam int SLOTS = 4;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic                loop_rst;
    logic                downloading;
    logic [SLOTS-1:0]    slot_req;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS*DW-1:0] slot_dout;
    logic [SLOTS-1:0]    slot_ok;
    logic                read_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack = 1'b0;
    logic                data_rdy  = 1'b0;
    logic [DW-1:0]       data_read = '0;
    logic                refresh_en;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] salt;
    int uniq = 1;
    logic [AW-1:0] grant_log[$];

    int ctl_phase = 0;
    int ctl_cnt   = 0;
    logic [AW-1:0] ctl_addr;

    always #5 clk = ~clk;

    jtgng_sdram_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .loop_rst(loop_rst), .downloading(downloading),
        .slot_req(slot_req), .slot_addr(slot_addr), .slot_dout(slot_dout),
        .slot_ok(slot_ok), .read_req(read_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy), .data_read(data_read),
        .refresh_en(refresh_en)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return salt ^ {a, 10'h000} ^ {10'h000, a};
    endfunction

    // SDRAM controller model: works on the falling edge, logs accepted addresses.
    always @(negedge clk) begin
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (rst) begin
            ctl_phase = 0;
        end else begin
            case (ctl_phase)
                0: if (read_req) begin
                       ctl_addr  = sdram_addr;
                       ctl_phase = 1;
                   end
                1: begin
                       sdram_ack = 1'b1;
                       grant_log.push_back(ctl_addr);
                       ctl_cnt   = 0;
                       ctl_phase = 2;
                   end
                default: begin
                       ctl_cnt++;
                       if (ctl_cnt == 5) begin
                           data_rdy  = 1'b1;
                           data_read = mem_word(ctl_addr);
                           ctl_phase = 0;
                       end
                   end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fresh(output logic [AW-1:0] a);
        uniq++;
        a = AW'(uniq << 16) | AW'($urandom_range(0, 32'h0000FFFF));
    endtask

    task automatic set_slot(input int s, input logic req, input logic [AW-1:0] a);
        slot_req[s] = req;
        slot_addr[s*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] dout_of(input int s);
        return slot_dout[s*DW +: DW];
    endfunction

    // Reference arbitration rule: first pending slot after the last granted one.
    function automatic int next_slot(input int last, input bit [SLOTS-1:0] pend);
        for (int k = 1; k <= SLOTS; k++) begin
            if (pend[(last + k) % SLOTS]) return (last + k) % SLOTS;
        end
        return -1;
    endfunction

    task automatic wait_log(input int n, input string tag);
        int k;
        k = 0;
        while (grant_log.size() < n && k < 80) begin
            step();
            k++;
        end
        chk({tag, "_grant_timeout"}, 64'(grant_log.size() >= n), 64'd1);
    endtask

    task automatic wait_rdy(input string tag);
        int k;
        k = 0;
        step();
        while (!data_rdy && k < 80) begin
            step();
            k++;
        end
        chk({tag, "_data_timeout"}, 64'(data_rdy), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        grant_log.delete();
    endtask

    initial begin
        logic [AW-1:0] a [SLOTS];
        logic [AW-1:0] b [SLOTS];
        logic [AW-1:0] x;
        logic [AW-1:0] y;
        int exp_order [SLOTS];
        int last;
        bit [SLOTS-1:0] pend;

        rst = 1'b1; loop_rst = 1'b0; downloading = 1'b0;
        slot_req = '0; slot_addr = '0;
        salt = $urandom;
        repeat (3) step();
        chk("rst_read_req",   64'(read_req),   64'd0);
        chk("rst_sdram_addr", 64'(sdram_addr), 64'd0);
        chk("rst_slot_ok",    64'(slot_ok),    64'd0);
        chk("rst_slot_dout",  64'(slot_dout == '0), 64'd1);
        chk("rst_refresh",    64'(refresh_en), 64'd0);
        rst = 1'b0;
        grant_log.delete();
        step(); step();

        // 1: cold miss, then cached hit without SDRAM traffic
        set_slot(0, 1'b1, 22'h00100);
        step();
        chk("t1_read_req",  64'(read_req),   64'd1);
        chk("t1_addr",      64'(sdram_addr), 64'h100);
        chk("t1_ok_early",  64'(slot_ok[0]), 64'd0);
        chk("t1_refresh",   64'(refresh_en), 64'd0);
        wait_rdy("t1");
        chk("t1_ok_fill",   64'(slot_ok[0]), 64'd1);
        chk("t1_dout",      64'(dout_of(0)), 64'(mem_word(22'h00100)));
        chk("t1_nreads",    64'(grant_log.size()), 64'd1);
        chk("t1_log0",      64'(grant_log[0]), 64'h100);
        slot_req[0] = 1'b0;
        step();
        chk("t1_ok_drop",   64'(slot_ok[0]), 64'd0);
        slot_req[0] = 1'b1;
        step();
        chk("t1_ok_hit",    64'(slot_ok[0]), 64'd1);
        chk("t1_dout_hit",  64'(dout_of(0)), 64'(mem_word(22'h00100)));
        repeat (8) step();
        chk("t1_no_reread", 64'(grant_log.size()), 64'd1);
        chk("t1_rreq_idle", 64'(read_req), 64'd0);

        // 2: simultaneous misses after reset, then again with pointer at slot 1
        slot_req = '0;
        do_reset();
        for (int s = 0; s < SLOTS; s++) begin
            fresh(a[s]);
            set_slot(s, 1'b1, a[s]);
        end
        last = SLOTS - 1; pend = '1;
        for (int k = 0; k < SLOTS; k++) begin
            exp_order[k] = next_slot(last, pend);
            pend[exp_order[k]] = 1'b0;
            last = exp_order[k];
        end
        wait_log(SLOTS, "t2a");
        repeat (8) step();
        for (int k = 0; k < SLOTS; k++)
            chk($sformatf("t2a_order%0d", k), 64'(grant_log[k]), 64'(a[exp_order[k]]));
        for (int s = 0; s < SLOTS; s++) begin
            chk($sformatf("t2a_ok%0d", s),   64'(slot_ok[s]), 64'd1);
            chk($sformatf("t2a_dout%0d", s), 64'(dout_of(s)), 64'(mem_word(a[s])));
        end

        slot_req = '0;
        step();
        grant_log.delete();
        fresh(x);
        set_slot(1, 1'b1, x);
        wait_log(1, "t2b_pre");
        wait_rdy("t2b_pre");
        for (int s = 0; s < SLOTS; s++) begin
            fresh(b[s]);
            set_slot(s, 1'b1, b[s]);
        end
        last = 1; pend = '1;
        for (int k = 0; k < SLOTS; k++) begin
            exp_order[k] = next_slot(last, pend);
            pend[exp_order[k]] = 1'b0;
            last = exp_order[k];
        end
        wait_log(SLOTS + 1, "t2b");
        repeat (8) step();
        for (int k = 0; k < SLOTS; k++)
            chk($sformatf("t2b_order%0d", k), 64'(grant_log[k+1]), 64'(b[exp_order[k]]));
        chk("t2b_ok_all", 64'(slot_ok), 64'hF);

        // 3: address change while the read is in flight
        slot_req = '0;
        step();
        grant_log.delete();
        set_slot(2, 1'b1, 22'h02000);
        wait_log(1, "t3a");
        chk("t3_log0", 64'(grant_log[0]), 64'h2000);
        set_slot(2, 1'b1, 22'h02001);
        wait_rdy("t3a");
        chk("t3_ok_stale", 64'(slot_ok[2]), 64'd0);
        step();
        chk("t3_ok_after", 64'(slot_ok[2]), 64'd0);
        wait_log(2, "t3b");
        chk("t3_log1", 64'(grant_log[1]), 64'h2001);
        wait_rdy("t3b");
        chk("t3_ok_new",   64'(slot_ok[2]), 64'd1);
        chk("t3_dout_new", 64'(dout_of(2)), 64'(mem_word(22'h02001)));

        // 4: download pulse during a read invalidates everything
        slot_req = '0;
        step();
        grant_log.delete();
        fresh(x);
        set_slot(1, 1'b1, x);
        wait_log(1, "t4a");
        downloading = 1'b1;
        step();
        downloading = 1'b0;
        wait_rdy("t4a");
        chk("t4_ok_fill", 64'(slot_ok[1]), 64'd0);
        step();
        chk("t4_ok_next", 64'(slot_ok[1]), 64'd0);
        wait_log(2, "t4b");
        chk("t4_refetch", 64'(grant_log[1]), 64'(x));
        wait_rdy("t4b");
        chk("t4_ok_refetch", 64'(slot_ok[1]), 64'd1);
        chk("t4_dout",       64'(dout_of(1)), 64'(mem_word(x)));
        set_slot(3, 1'b1, b[3]);
        wait_log(3, "t4c");
        chk("t4_cleared_slot3", 64'(grant_log[2]), 64'(b[3]));
        wait_rdy("t4c");
        chk("t4_ok3", 64'(slot_ok[3]), 64'd1);

        // 5: refresh gating, and loop_rst blocking grants
        slot_req = '0;
        repeat (20) step();
        grant_log.delete();
        chk("t5_refresh_idle", 64'(refresh_en), 64'd1);
        chk("t5_rreq_idle",    64'(read_req),   64'd0);
        fresh(x);
        set_slot(1, 1'b1, x);
        step();
        chk("t5_grant",        64'(read_req),   64'd1);
        chk("t5_refresh_off",  64'(refresh_en), 64'd0);
        wait_rdy("t5a");
        chk("t5_ok",           64'(slot_ok[1]), 64'd1);
        fresh(y);
        loop_rst = 1'b1;
        set_slot(1, 1'b1, y);
        repeat (4) step();
        chk("t5_loop_rst_rreq",    64'(read_req),   64'd0);
        chk("t5_loop_rst_refresh", 64'(refresh_en), 64'd0);
        loop_rst = 1'b0;
        step();
        chk("t5_release_rreq", 64'(read_req),   64'd1);
        chk("t5_release_addr", 64'(sdram_addr), 64'(y));
        wait_rdy("t5b");
        chk("t5_ok_y", 64'(slot_ok[1]), 64'd1);

        // 6: reset while waiting for the controller's ack
        slot_req = '0;
        step();
        grant_log.delete();
        fresh(x);
        set_slot(0, 1'b1, x);
        step();
        chk("t6_pre_rreq", 64'(read_req), 64'd1);
        rst = 1'b1;
        step();
        chk("t6_rreq",    64'(read_req),  64'd0);
        chk("t6_ok",      64'(slot_ok),   64'd0);
        chk("t6_dout",    64'(slot_dout == '0), 64'd1);
        chk("t6_refresh", 64'(refresh_en), 64'd0);
        set_slot(1, 1'b1, y);
        rst = 1'b0;
        wait_log(2, "t6");
        chk("t6_first",  64'(grant_log[0]), 64'(x));
        chk("t6_second", 64'(grant_log[1]), 64'(y));
        repeat (8) step();
        chk("t6_ok_both", 64'(slot_ok[1:0]), 64'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
